rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Registered N-way arbiter that shares one downstream resource (bus port, FIFO write side, execution slot) between `PORTS` requesters. Each cycle it chooses one requester using fixed priority or round-robin, holds the grant according to the blocking mode, and presents the winner as a one-hot vector and as a binary index. It wraps the existing `priority_encoder` datapath with grant and mask state. It sits between the requester front-ends and the shared-resource mux select.

## Interface
- `PORTS`, 4: number of requesters, ≥1.
- `ARB_TYPE_ROUND_ROBIN`, 1: 1 = round-robin, 0 = fixed priority.
- `ARB_BLOCK`, 1: 1 = hold the grant while the blocking condition is true; 0 = re-arbitrate every cycle.
- `ARB_BLOCK_ACK`, 1: with `ARB_BLOCK`=1, 1 = hold until acknowledge, 0 = hold while the request stays high.
- `LSB_HIGH_PRIORITY`, 0: 0 = highest index wins ties; 1 = index 0 wins ties.
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `request` in `PORTS`: per-requester request level.
- `acknowledge` in `PORTS`: per-requester completion pulse; only the granted bit is sampled.
- `grant` out `PORTS`: one-hot grant, or zero.
- `grant_valid` out 1: high when `grant` is nonzero.
- `grant_encoded` out `$clog2(PORTS)` (min 1): index of the granted requester.

## Operation
- Reset values: `grant`=0, `grant_valid`=0, `grant_encoded`=0, `mask`=0.
- State is implicit, two states:
  - IDLE: `grant_valid`=0.
  - HELD: `grant_valid`=1, index g.
- `hold` is true only in HELD with `ARB_BLOCK`=1, and then:
  - `ARB_BLOCK_ACK`=0: `request[g]`=1.
  - `ARB_BLOCK_ACK`=1: `acknowledge[g]`=0.
- Next-state priority, evaluated each edge:
  1. `hold`: all outputs and `mask` unchanged.
  2. Else if `request & mask` is nonzero and round-robin: grant the encoder winner of `request & mask`.
  3. Else if `request` is nonzero: grant the encoder winner of `request`.
  4. Else: go to IDLE with `grant`=0, `grant_valid`=0, `grant_encoded`=0. `mask` is unchanged.
- Mask update on every new grant to index g (round-robin only; fixed priority keeps `mask`=0):
  - `LSB_HIGH_PRIORITY`=0: `mask` = ones in bits [g-1:0]. The next winner is strictly below g, then it wraps to the top.
  - `LSB_HIGH_PRIORITY`=1: `mask` = ones in bits [PORTS-1:g+1]. The next winner is strictly above g, then it wraps to 0.
- Acknowledge on a non-granted bit is ignored. `acknowledge[g]` in the same cycle as `request[g]` drop is a release.
- Release and re-arbitration happen in the same edge. There is no idle bubble when another request is pending.
- A sole requester can be re-granted immediately after release: mask miss, then the unmasked path.
- `ARB_BLOCK`=0: steps 2–4 run every cycle, so the grant can move each cycle.
- `rst` asserted mid-grant: all outputs clear immediately (asynchronously). The first arbitration after deassert uses `mask`=0.

## Timing
- Latency is 1 cycle: a request sampled at edge N gives its grant visible after edge N.
- All outputs are registered, with no combinational path from inputs to outputs.
- `acknowledge` sampled at edge N releases the grant at edge N. The new grant is visible in the same cycle N+ as the release.
- Requesters must keep `request` high until granted. Dropping it earlier just removes the requester from arbitration.

## Structure
- `rr_arbiter_pkg`:
  - `arb_mode_e` enum (FIXED, ROUND_ROBIN).
  - Helper functions `mask_below(idx)` and `mask_above(idx)`, parameterised on width.
- Sub-module: two `priority_encoder` instances, `WIDTH=PORTS`, with `LSB_HIGH_PRIORITY` passed through. One takes `request`, the other `request & mask`; their `output_unencoded` supplies `grant`.
- Expected size is roughly 150 lines of RTL.

## Test plan
All scenarios use `PORTS`=4.
- Reset: hold `rst` with `request`=4'b1111 → `grant`=0, `grant_valid`=0. First edge after deassert → `grant`=4'b1000, `grant_encoded`=3.
- Round-robin with acknowledge (defaults): `request`=4'b1111 constant, `acknowledge`=`grant` each cycle → `grant_encoded` sequence 3,2,1,0,3,2.
- Fixed priority (`ARB_TYPE_ROUND_ROBIN`=0, `LSB_HIGH_PRIORITY`=1): `request`=4'b0110 with acks each cycle → `grant_encoded` stays 1 on every cycle.
- Hold-on-request (`ARB_BLOCK_ACK`=0): grant index 2 with `request`=4'b1100 held for 5 cycles → `grant` stays 4'b0100. Drop bit 2 → next edge gives `grant`=4'b1000.
- Ignored ack / sole requester: grant index 1 while `acknowledge`=4'b0001 → no change. `acknowledge`=4'b0010 with `request`=4'b0010 still high → `grant`=4'b0010 again, with no IDLE cycle.
- Async reset mid-grant: `rst` pulsed between edges while `grant_valid`=1 → outputs go to 0 before the next edge. After reset, `request`=4'b0001 → `grant_encoded`=0.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and mask helpers for the round-robin arbiter.
package rr_arbiter_pkg;

    // Widest arbiter the mask helpers support.
    localparam int MAX_PORTS = 64;

    typedef enum logic {
        FIXED       = 1'b0,
        ROUND_ROBIN = 1'b1
    } arb_mode_e;

    // Implicit arbiter state, derived from grant_valid; exposed internally as w_state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } arb_state_e;

    // Ones in bits [idx-1:0], limited to the first 'width' bits.
    function automatic logic [MAX_PORTS-1:0] mask_below(input int idx, input int width);
        logic [MAX_PORTS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i < width && i < idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Ones in bits [width-1:idx+1].
    function automatic logic [MAX_PORTS-1:0] mask_above(input int idx, input int width);
        logic [MAX_PORTS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i < width && i > idx) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// Combinational priority encoder: picks one set bit of the input vector and
// returns it as valid flag, binary index and one-hot vector.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]                              input_unencoded,
    output logic                                          output_valid,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]  output_encoded,
    output logic [WIDTH-1:0]                              output_unencoded
);

    localparam int W_ENC = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Scan so that the last hit is the winner: descending scan for LSB priority,
    // ascending scan for MSB priority.
    always_comb begin
        output_valid     = 1'b0;
        output_encoded   = '0;
        output_unencoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) begin
                    output_valid        = 1'b1;
                    output_encoded      = W_ENC'(i);
                    output_unencoded    = '0;
                    output_unencoded[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) begin
                    output_valid        = 1'b1;
                    output_encoded      = W_ENC'(i);
                    output_unencoded    = '0;
                    output_unencoded[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter with fixed-priority or round-robin selection and
// optional grant holding (until acknowledge, or while the request stays high).
// Handshake: a requester raises request[i] and keeps it high until grant[i];
// in acknowledge mode it pulses acknowledge[i] while granted to release, and the
// next winner is granted on that same edge.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK            = 1,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PORTS-1:0]                              request,
    input  logic [PORTS-1:0]                              acknowledge,
    output logic [PORTS-1:0]                              grant,
    output logic                                          grant_valid,
    output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0]  grant_encoded
);

    localparam int        W_ENC = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam arb_mode_e MODE  = (ARB_TYPE_ROUND_ROBIN != 0) ? ROUND_ROBIN : FIXED;

    logic [PORTS-1:0] r_grant;
    logic             r_grant_valid;
    logic [W_ENC-1:0] r_grant_encoded;
    logic [PORTS-1:0] r_mask;

    logic [PORTS-1:0] w_grant_nxt;
    logic             w_valid_nxt;
    logic [W_ENC-1:0] w_enc_nxt;
    logic [PORTS-1:0] w_mask_nxt;

    logic [PORTS-1:0] w_masked_req;
    logic             w_req_valid;
    logic [W_ENC-1:0] w_req_enc;
    logic [PORTS-1:0] w_req_onehot;
    logic             w_msk_valid;
    logic [W_ENC-1:0] w_msk_enc;
    logic [PORTS-1:0] w_msk_onehot;

    arb_state_e       w_state;
    logic             w_hold;

    assign w_masked_req = request & r_mask;
    assign w_state      = r_grant_valid ? ST_HELD : ST_IDLE;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_req (
        .input_unencoded  (request),
        .output_valid     (w_req_valid),
        .output_encoded   (w_req_enc),
        .output_unencoded (w_req_onehot)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .input_unencoded  (w_masked_req),
        .output_valid     (w_msk_valid),
        .output_encoded   (w_msk_enc),
        .output_unencoded (w_msk_onehot)
    );

    // Mask applied after granting idx: only requesters after idx in rotation order.
    function automatic logic [PORTS-1:0] next_mask(input logic [W_ENC-1:0] idx);
        logic [MAX_PORTS-1:0] m;
        if (MODE == FIXED) begin
            m = '0;
        end else if (LSB_HIGH_PRIORITY != 0) begin
            m = mask_above(int'(idx), PORTS);
        end else begin
            m = mask_below(int'(idx), PORTS);
        end
        return m[PORTS-1:0];
    endfunction

    // Hold the current grant while the blocking condition for the granted bit is true.
    always_comb begin
        w_hold = 1'b0;
        if (w_state == ST_HELD && ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) begin
                w_hold = ~|(acknowledge & r_grant);
            end else begin
                w_hold = |(request & r_grant);
            end
        end
    end

    // Next grant and mask: hold, masked winner, unmasked winner, or idle.
    always_comb begin
        w_grant_nxt = r_grant;
        w_valid_nxt = r_grant_valid;
        w_enc_nxt   = r_grant_encoded;
        w_mask_nxt  = r_mask;
        if (!w_hold) begin
            if (MODE == ROUND_ROBIN && w_msk_valid) begin
                w_grant_nxt = w_msk_onehot;
                w_valid_nxt = 1'b1;
                w_enc_nxt   = w_msk_enc;
                w_mask_nxt  = next_mask(w_msk_enc);
            end else if (w_req_valid) begin
                w_grant_nxt = w_req_onehot;
                w_valid_nxt = 1'b1;
                w_enc_nxt   = w_req_enc;
                w_mask_nxt  = next_mask(w_req_enc);
            end else begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_enc_nxt   = '0;
            end
        end
    end

    // Grant and mask registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_encoded <= '0;
            r_mask          <= '0;
        end else begin
            r_grant         <= w_grant_nxt;
            r_grant_valid   <= w_valid_nxt;
            r_grant_encoded <= w_enc_nxt;
            r_mask          <= w_mask_nxt;
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three configurations (round-robin/ack, fixed priority
// LSB-first, round-robin hold-on-request), directed scenarios plus a random
// run of the default configuration against a rotating-pointer model.
module tb_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] req_a, ack_a, grant_a;
    logic [3:0] req_b, ack_b, grant_b;
    logic [3:0] req_c, ack_c, grant_c;
    logic       valid_a, valid_b, valid_c;
    logic [1:0] enc_a, enc_b, enc_c;

    rr_arbiter #(
        .PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
        .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0)
    ) dut_a (
        .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a),
        .grant(grant_a), .grant_valid(valid_a), .grant_encoded(enc_a)
    );

    rr_arbiter #(
        .PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1),
        .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)
    ) dut_b (
        .clk(clk), .rst(rst), .request(req_b), .acknowledge(ack_b),
        .grant(grant_b), .grant_valid(valid_b), .grant_encoded(enc_b)
    );

    rr_arbiter #(
        .PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
        .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0)
    ) dut_c (
        .clk(clk), .rst(rst), .request(req_c), .acknowledge(ack_c),
        .grant(grant_c), .grant_valid(valid_c), .grant_encoded(enc_c)
    );

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    // Model state for the random run: pointer p means "search below p first".
    bit m_valid;
    int m_g;
    int m_p;

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got valid=%0b enc=%0d grant=%b, expected valid=%0b enc=%0d grant=%b",
                     tag, obs[6], obs[5:4], obs[3:0], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    function automatic logic [6:0] exp_of(input bit v, input int idx);
        logic [1:0] e;
        logic [3:0] g;
        e = 2'(idx);
        g = 4'(1 << idx);
        return v ? {1'b1, e, g} : 7'b0;
    endfunction

    function automatic logic [6:0] obs_of(input int sel);
        case (sel)
            0:       return {valid_a, enc_a, grant_a};
            1:       return {valid_b, enc_b, grant_b};
            default: return {valid_c, enc_c, grant_c};
        endcase
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic run_cycle(input int sel, input logic [3:0] req, input logic [3:0] ack,
                             input logic [6:0] exp, input string tag);
        case (sel)
            0:       begin req_a = req; ack_a = ack; end
            1:       begin req_b = req; ack_b = ack; end
            default: begin req_c = req; ack_c = ack; end
        endcase
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_val(tag, obs_of(sel), exp_q.pop_front());
    endtask

    // Rotating-pointer reference for the default configuration.
    task automatic model_step(input logic [3:0] req, input logic [3:0] ack);
        int w;
        if (m_valid && !ack[m_g]) return;
        w = -1;
        for (int i = m_p - 1; i >= 0; i--) if (req[i] && w < 0) w = i;
        for (int i = 3; i >= 0; i--) if (req[i] && w < 0) w = i;
        if (w >= 0) begin
            m_valid = 1'b1;
            m_g     = w;
            m_p     = w;
        end else begin
            m_valid = 1'b0;
            m_g     = 0;
        end
    endtask

    initial begin
        int seq[5] = '{2, 1, 0, 3, 2};
        int prev;
        logic [3:0] r, a;

        req_a = 4'b1111; ack_a = '0;
        req_b = '0;      ack_b = '0;
        req_c = '0;      ack_c = '0;

        // Reset held with all requests high.
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", obs_of(0), 7'b0);
        rst = 1'b0;
        run_cycle(0, 4'b1111, 4'b0000, exp_of(1, 3), "reset_first");

        // Round-robin rotation with acknowledge each cycle.
        prev = 3;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 4'b1111, 4'(1 << prev), exp_of(1, seq[i]), "rr_ack");
            prev = seq[i];
        end

        // Ignored ack on a non-granted bit, then sole-requester re-grant.
        run_cycle(0, 4'b0010, 4'b0100, exp_of(1, 1), "rr_to_1");
        run_cycle(0, 4'b0010, 4'b0001, exp_of(1, 1), "ign_ack");
        run_cycle(0, 4'b0010, 4'b0001, exp_of(1, 1), "ign_ack");
        run_cycle(0, 4'b0010, 4'b0010, exp_of(1, 1), "sole_regrant");
        run_cycle(0, 4'b0000, 4'b0010, exp_of(0, 0), "release_idle");
        run_cycle(0, 4'b0010, 4'b0000, exp_of(1, 1), "regrant");

        // Asynchronous reset between edges while granted.
        rst = 1'b1;
        #1;
        check_val("async_rst", obs_of(0), 7'b0);
        #1;
        rst = 1'b0;
        run_cycle(0, 4'b0001, 4'b0000, exp_of(1, 0), "post_rst");

        // Fixed priority, LSB first.
        run_cycle(1, 4'b0110, 4'b0000, exp_of(1, 1), "fp_first");
        repeat (4) run_cycle(1, 4'b0110, 4'b0010, exp_of(1, 1), "fp_ack");

        // Hold while request stays high; acknowledge has no effect in this mode.
        run_cycle(2, 4'b0100, 4'b0000, exp_of(1, 2), "hr_first");
        repeat (5) run_cycle(2, 4'b1100, 4'b0100, exp_of(1, 2), "hr_hold");
        run_cycle(2, 4'b1000, 4'b0000, exp_of(1, 3), "hr_drop");

        // Random traffic against the model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_g     = 0;
        m_p     = 0;
        for (int i = 0; i < 300; i++) begin
            r = 4'($urandom_range(0, 15));
            a = 4'($urandom_range(0, 15));
            model_step(r, a);
            run_cycle(0, r, a, exp_of(m_valid, m_g), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
